mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage access engine: consumes the instruction held in the EX/MEM pipeline register, performs byte-serial loads and stores on the 8-bit RAM port through the memory arbiter, and presents write-back results to MEM/WB. It sits between the EX/MEM register and the MEM/WB register. It raises a stall request to the stall controller for the whole duration of any memory access. Non-memory instructions pass straight through with zero added latency.

## Interface
Parameters: none; widths come from `defines.vh` (`instIdxRange`, `regIdxRange`, `dataRange`).
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; 0 freezes all state and holds all outputs
- instIdx_in  input  `instIdxRange`  instruction id from EX/MEM
- memAddr_in  input  18  byte address
- valStore_in  input  32  store data
- rdE_in / rdIdx_in / rdData_in  input  1 / `regIdxRange` / 32  write-back request from EX
- mem_req_out  output  1  byte access request to the arbiter
- mem_we_out  output  1  1 = write, 0 = read
- mem_addr_out  output  18  byte address
- mem_dout_out  output  8  write byte
- mem_grant_in  input  1  arbiter accepted this cycle's request
- mem_din_in  input  8  read byte; valid the cycle after a granted read
- stallReq_out  output  1  to the stall controller; 1 holds stages 0–4
- rdE_out / rdIdx_out / rdData_out  output  1 / `regIdxRange` / 32  to MEM/WB and forwarding

## Operation
- Memory ops are `idLB`, `idLH`, `idLW`, `idLBU`, `idLHU`, `idSB`, `idSH` and `idSW`.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W. All other ids are non-memory.
- FSM states:
  - IDLE:
    - Non-memory op: stallReq_out=0 and rd*_out = rd*_in combinationally.
    - Memory op: stallReq_out=1; latch address, store data, op and rdIdx_in; cnt=0; go to ACCESS.
  - ACCESS:
    - Drive mem_req_out=1, mem_addr_out = addr + cnt (mod 2^18), mem_we_out = store.
    - mem_dout_out = valStore[8cnt+7:8cnt].
    - On mem_grant_in, cnt increments.
    - On the grant of byte n-1: a store goes to DONE, a load goes to WAIT_LAST.
    - Request signals stay stable while the grant is withheld.
  - WAIT_LAST: mem_req_out=0; capture the final read byte; go to DONE.
  - DONE:
    - stallReq_out=0.
    - Loads: rdE_out=1, rdIdx_out = latched index, rdData_out = assembled result.
    - Stores: rdE_out=0, rdIdx_out=`regNOP`, rdData_out=0.
    - Next cycle go to IDLE unconditionally.
- Load assembly:
  - The byte returned for request k lands in result[8k+7:8k], captured the cycle after its grant.
  - Captures are pipelined with later requests.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW uses the word as-is.
- stallReq_out is 1 in ACCESS and WAIT_LAST, and in IDLE when a memory op is present.
- Address alignment is not checked; halfword and word accesses may straddle address 0x3FFFF→0x00000.
- rdy_in=0: FSM, counter and capture registers hold; outputs unchanged.

## Timing
- Reset (async, rst_in=0):
  - FSM goes to IDLE; cnt=0; captured data=0.
  - mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_dout_out=0.
  - stallReq_out=0, rdE_out=0, rdIdx_out=`regNOP`, rdData_out=0.
  - Holds regardless of instIdx_in until the first rising edge after release.
- Reset mid-access abandons the access; no further requests are issued.
- Non-memory op: 0 extra cycles.
- Store, grant every cycle: 1 (IDLE) + n (ACCESS) + 1 (DONE) = n+2 cycles. The stall is high for n+1 of them.
- Load, grant every cycle: n+3 cycles. The stall is high for n+2 of them.
- Each withheld grant adds one cycle.
- DONE is the only cycle in which a memory op's result is presented. The pipeline advances at the end of that cycle, so IDLE sees the next instruction.
- A grant arriving while mem_req_out=0 is ignored.

## Test plan
- LW at 0x00100, RAM bytes 78 56 34 12, grant held high.
  - Required: requests at 0x100–0x103 on cycles 1–4.
  - stallReq_out high on cycles 0–5.
  - Cycle 6: rdE_out=1, rdData_out=0x12345678.
- LB and LBU at an address holding 0x80 → rdData_out=0xFFFFFF80 and 0x00000080 respectively; LH of 0x8001 → 0xFFFF8001.
- SH with valStore 0x0000ABCD at 0x3FFFF → writes 0xCD to 0x3FFFF, then 0xAB to 0x00000. rdE_out=0 in DONE.
- SW 0xDEADBEEF with the grant withheld 3 cycles before byte 2.
  - Required: address 0x002/data 0xAD stable across the wait.
  - Total 9 cycles; RAM receives EF BE AD DE.
- Assert rst_in low in the cycle after byte 1 of an LW is granted.
  - Required: mem_req_out, stallReq_out and rd*_out go to reset values immediately, without waiting for the clock edge.
  - No requests until a new op is presented after release.
- ADD with rdE_in=1, rdIdx_in=5, rdData_in=0x7 in IDLE → stallReq_out=0 and rd*_out equal the inputs in the same cycle; mem_req_out stays 0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Byte-wide RAM port between the MEM-stage access engine and the memory arbiter.
interface mem_access_unit_if;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [17:0] mem_addr_out;
    logic [7:0]  mem_dout_out;
    logic        mem_grant_in;
    logic [7:0]  mem_din_in;

    modport master (
        output mem_req_out,
        output mem_we_out,
        output mem_addr_out,
        output mem_dout_out,
        input  mem_grant_in,
        input  mem_din_in
    );

    modport slave (
        input  mem_req_out,
        input  mem_we_out,
        input  mem_addr_out,
        input  mem_dout_out,
        output mem_grant_in,
        output mem_din_in
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: byte-serial loads/stores over the 8-bit RAM port,
// stalling the pipeline for the whole access.
module mem_access_unit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [5:0]  instIdx_in,
    input  logic [17:0] memAddr_in,
    input  logic [31:0] valStore_in,
    input  logic        rdE_in,
    input  logic [4:0]  rdIdx_in,
    input  logic [31:0] rdData_in,
    mem_access_unit_if.master mem,
    output logic        stallReq_out,
    output logic        rdE_out,
    output logic [4:0]  rdIdx_out,
    output logic [31:0] rdData_out
);

    localparam logic [5:0] ID_LB  = 6'd11;
    localparam logic [5:0] ID_LH  = 6'd12;
    localparam logic [5:0] ID_LW  = 6'd13;
    localparam logic [5:0] ID_LBU = 6'd14;
    localparam logic [5:0] ID_LHU = 6'd15;
    localparam logic [5:0] ID_SB  = 6'd16;
    localparam logic [5:0] ID_SH  = 6'd17;
    localparam logic [5:0] ID_SW  = 6'd18;
    localparam logic [4:0] REG_NOP = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic        mem_op, op_st, op_sgn;
    logic [1:0]  op_last;

    logic [17:0] addr_q;
    logic [31:0] store_q;
    logic [4:0]  rd_idx_q;
    logic        st_q, sgn_q;
    logic [1:0]  last_q;
    logic [1:0]  cnt;
    logic        cap_pend;
    logic [1:0]  cap_idx;
    logic [31:0] data_q;
    logic [31:0] ld_data;
    logic        grant_ok;

    always_comb begin
        mem_op  = 1'b0;
        op_st   = 1'b0;
        op_sgn  = 1'b0;
        op_last = 2'd0;
        unique case (instIdx_in)
            ID_LB:  begin mem_op = 1'b1; op_sgn = 1'b1; op_last = 2'd0; end
            ID_LH:  begin mem_op = 1'b1; op_sgn = 1'b1; op_last = 2'd1; end
            ID_LW:  begin mem_op = 1'b1; op_last = 2'd3; end
            ID_LBU: begin mem_op = 1'b1; op_last = 2'd0; end
            ID_LHU: begin mem_op = 1'b1; op_last = 2'd1; end
            ID_SB:  begin mem_op = 1'b1; op_st = 1'b1; op_last = 2'd0; end
            ID_SH:  begin mem_op = 1'b1; op_st = 1'b1; op_last = 2'd1; end
            ID_SW:  begin mem_op = 1'b1; op_st = 1'b1; op_last = 2'd3; end
            default: ;
        endcase
    end

    assign grant_ok = (state == S_ACCESS) && mem.mem_grant_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= S_IDLE;
        else if (rdy_in)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (mem_op) state_nx = S_ACCESS;
            S_ACCESS: if (grant_ok && cnt == last_q)
                          state_nx = st_q ? S_DONE : S_WAIT;
            S_WAIT:   state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Read bytes arrive one cycle after their grant, so the capture
    // slot trails the request counter by one cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q   <= '0;
            store_q  <= '0;
            rd_idx_q <= REG_NOP;
            st_q     <= 1'b0;
            sgn_q    <= 1'b0;
            last_q   <= 2'd0;
            cnt      <= 2'd0;
            cap_pend <= 1'b0;
            cap_idx  <= 2'd0;
            data_q   <= '0;
        end else if (rdy_in) begin
            cap_pend <= grant_ok && !st_q;
            cap_idx  <= cnt;
            if (cap_pend)
                data_q[{cap_idx, 3'b000} +: 8] <= mem.mem_din_in;
            if (state == S_IDLE && mem_op) begin
                addr_q   <= memAddr_in;
                store_q  <= valStore_in;
                rd_idx_q <= rdIdx_in;
                st_q     <= op_st;
                sgn_q    <= op_sgn;
                last_q   <= op_last;
                cnt      <= 2'd0;
                data_q   <= '0;
            end else if (grant_ok) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        unique case (last_q)
            2'd0:    ld_data = {{24{sgn_q & data_q[7]}}, data_q[7:0]};
            2'd1:    ld_data = {{16{sgn_q & data_q[15]}}, data_q[15:0]};
            default: ld_data = data_q;
        endcase
    end

    logic        req, we;
    logic [17:0] addr;
    logic [7:0]  dout;

    // Outputs are forced to idle values while reset is held, even
    // though IDLE would otherwise pass EX results through.
    always_comb begin
        req          = 1'b0;
        we           = 1'b0;
        addr         = '0;
        dout         = '0;
        stallReq_out = 1'b0;
        rdE_out      = 1'b0;
        rdIdx_out    = REG_NOP;
        rdData_out   = '0;
        if (rst_in) begin
            unique case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        stallReq_out = 1'b1;
                    end else begin
                        rdE_out    = rdE_in;
                        rdIdx_out  = rdIdx_in;
                        rdData_out = rdData_in;
                    end
                end
                S_ACCESS: begin
                    req          = 1'b1;
                    we           = st_q;
                    addr         = addr_q + {16'd0, cnt};
                    dout         = store_q[{cnt, 3'b000} +: 8];
                    stallReq_out = 1'b1;
                end
                S_WAIT: stallReq_out = 1'b1;
                S_DONE: begin
                    if (!st_q) begin
                        rdE_out    = 1'b1;
                        rdIdx_out  = rd_idx_q;
                        rdData_out = ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req_out  = req;
    assign mem.mem_we_out   = we;
    assign mem.mem_addr_out = addr;
    assign mem.mem_dout_out = dout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM/arbiter model plus result and write
// scoreboards.
module tb_mem_access_unit;

    localparam logic [5:0] ID_NOP = 6'd0;
    localparam logic [5:0] ID_ADD = 6'd20;
    localparam logic [5:0] ID_LB  = 6'd11;
    localparam logic [5:0] ID_LH  = 6'd12;
    localparam logic [5:0] ID_LW  = 6'd13;
    localparam logic [5:0] ID_LBU = 6'd14;
    localparam logic [5:0] ID_LHU = 6'd15;
    localparam logic [5:0] ID_SB  = 6'd16;
    localparam logic [5:0] ID_SH  = 6'd17;
    localparam logic [5:0] ID_SW  = 6'd18;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  instIdx_in;
    logic [17:0] memAddr_in;
    logic [31:0] valStore_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        stallReq_out;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    logic        gnt;
    logic [7:0]  din_q;

    always #5 clk_in = ~clk_in;

    mem_access_unit_if bus ();
    assign bus.mem_grant_in = gnt;
    assign bus.mem_din_in   = din_q;

    mem_access_unit dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .instIdx_in   (instIdx_in),
        .memAddr_in   (memAddr_in),
        .valStore_in  (valStore_in),
        .rdE_in       (rdE_in),
        .rdIdx_in     (rdIdx_in),
        .rdData_in    (rdData_in),
        .mem          (bus),
        .stallReq_out (stallReq_out),
        .rdE_out      (rdE_out),
        .rdIdx_out    (rdIdx_out),
        .rdData_out   (rdData_out)
    );

    typedef struct packed {
        logic        e;
        logic [4:0]  i;
        logic [31:0] d;
    } res_t;

    typedef struct packed {
        logic [17:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0] ram [0:262143];
    res_t res_q[$];
    wr_t  wr_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [5:0] op);
        case (op)
            ID_LB, ID_LBU, ID_SB: return 1;
            ID_LH, ID_LHU, ID_SH: return 2;
            ID_LW, ID_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    // RAM behind the arbiter: writes checked against the write scoreboard
    always @(posedge clk_in) begin : ram_model
        wr_t w;
        if (bus.mem_req_out && gnt) begin
            if (bus.mem_we_out) begin
                ram[bus.mem_addr_out] <= bus.mem_dout_out;
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", wr_q.size(), 1);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr_out), 32'(w.a));
                    chk("wr_data", 32'(bus.mem_dout_out), 32'(w.d));
                end
            end else begin
                din_q <= ram[bus.mem_addr_out];
            end
        end
    end

    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [17:0] a, input logic [31:0] sv,
                          input logic [4:0] rdi, input logic [31:0] exp_d,
                          input int gap_at, input int gap_len);
        int n, cyc, granted, held, exp_cyc;
        bit st, done;
        res_t r;
        logic [17:0] ea;
        n  = nbytes(op);
        st = (op == ID_SB) || (op == ID_SH) || (op == ID_SW);
        exp_cyc = (n == 0) ? 1 : n + (st ? 2 : 3) + gap_len;
        instIdx_in  = op;
        memAddr_in  = a;
        valStore_in = sv;
        rdE_in      = 1'b1;
        rdIdx_in    = rdi;
        rdData_in   = (n == 0) ? exp_d : 32'h5555_5555;
        if (n == 0)   r = {1'b1, rdi, exp_d};
        else if (st)  r = {1'b0, 5'd0, 32'd0};
        else          r = {1'b1, rdi, exp_d};
        res_q.push_back(r);
        if (st)
            for (int k = 0; k < n; k++)
                wr_q.push_back({a + 18'(k), sv[8*k +: 8]});
        granted = 0;
        held    = 0;
        cyc     = 0;
        done    = 0;
        while (!done && cyc < 40) begin
            gnt = !(granted == gap_at && held < gap_len);
            @(negedge clk_in);
            if (bus.mem_req_out) begin
                ea = a + 18'(granted);
                chk({tag, "_addr"}, 32'(bus.mem_addr_out), 32'(ea));
                chk({tag, "_we"}, 32'(bus.mem_we_out), 32'(st));
                if (st)
                    chk({tag, "_dout"}, 32'(bus.mem_dout_out),
                        32'(sv[8*granted +: 8]));
                if (gnt) granted++;
                else     held++;
            end
            if (!stallReq_out) begin
                r = res_q.pop_front();
                chk({tag, "_rdE"}, 32'(rdE_out), 32'(r.e));
                chk({tag, "_rdIdx"}, 32'(rdIdx_out), 32'(r.i));
                chk({tag, "_rdData"}, rdData_out, r.d);
                chk({tag, "_cycles"}, cyc + 1, exp_cyc);
                chk({tag, "_req_done"}, 32'(bus.mem_req_out), 0);
                done = 1;
            end
            @(posedge clk_in);
            #1;
            cyc++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, cyc, exp_cyc);
            r = res_q.pop_front();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},   32'(bus.mem_req_out), 0);
        chk({tag, "_we"},    32'(bus.mem_we_out), 0);
        chk({tag, "_addr"},  32'(bus.mem_addr_out), 0);
        chk({tag, "_dout"},  32'(bus.mem_dout_out), 0);
        chk({tag, "_stall"}, 32'(stallReq_out), 0);
        chk({tag, "_rdE"},   32'(rdE_out), 0);
        chk({tag, "_rdIdx"}, 32'(rdIdx_out), 0);
        chk({tag, "_rdData"}, rdData_out, 0);
    endtask

    initial begin
        logic [17:0] ra;
        logic [31:0] rw;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h100] = 8'h78;
        ram[18'h101] = 8'h56;
        ram[18'h102] = 8'h34;
        ram[18'h103] = 8'h12;
        ram[18'h200] = 8'h80;
        ram[18'h300] = 8'h01;
        ram[18'h301] = 8'h80;
        din_q = 8'h00;

        rst_in      = 1'b0;
        rdy_in      = 1'b1;
        gnt         = 1'b0;
        instIdx_in  = ID_LW;
        memAddr_in  = 18'h100;
        valStore_in = 32'h0;
        rdE_in      = 1'b1;
        rdIdx_in    = 5'd3;
        rdData_in   = 32'h1234;
        #2;
        chk_reset_outs("reset");
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        chk_reset_outs("reset_held");
        instIdx_in = ID_NOP;
        rdE_in     = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        run_op("add", ID_ADD, 18'h0, 32'h0, 5'd5, 32'h7, -1, 0);
        run_op("lw", ID_LW, 18'h100, 32'h0, 5'd1, 32'h1234_5678, -1, 0);
        run_op("lb", ID_LB, 18'h200, 32'h0, 5'd2, 32'hFFFF_FF80, -1, 0);
        run_op("lbu", ID_LBU, 18'h200, 32'h0, 5'd3, 32'h0000_0080, -1, 0);
        run_op("lh", ID_LH, 18'h300, 32'h0, 5'd4, 32'hFFFF_8001, -1, 0);
        run_op("sh_wrap", ID_SH, 18'h3FFFF, 32'h0000_ABCD, 5'd6, 32'h0, -1, 0);
        run_op("lhu_wrap", ID_LHU, 18'h3FFFF, 32'h0, 5'd7, 32'h0000_ABCD, -1, 0);
        run_op("sw_gap", ID_SW, 18'h0, 32'hDEAD_BEEF, 5'd8, 32'h0, 2, 3);
        run_op("lw_gap", ID_LW, 18'h0, 32'h0, 5'd9, 32'hDEAD_BEEF, -1, 0);

        // Reset in the cycle after byte 1 of a load is granted
        instIdx_in = ID_LW;
        memAddr_in = 18'h100;
        rdIdx_in   = 5'd3;
        rdE_in     = 1'b1;
        gnt        = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        chk("rst_mid_pre_req", 32'(bus.mem_req_out), 1);
        rst_in = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_mid_held_req", 32'(bus.mem_req_out), 0);
        chk("rst_mid_held_stall", 32'(stallReq_out), 0);
        instIdx_in = ID_NOP;
        rdE_in     = 1'b0;
        rst_in     = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            chk("rst_after_req", 32'(bus.mem_req_out), 0);
            chk("rst_after_stall", 32'(stallReq_out), 0);
        end
        @(posedge clk_in);
        #1;
        run_op("lw_after_rst", ID_LW, 18'h100, 32'h0, 5'd10, 32'h1234_5678, -1, 0);

        for (int i = 0; i < 4; i++) begin
            ra = 18'($urandom_range(0, 262143));
            rw = $urandom;
            run_op("rnd_sw", ID_SW, ra, rw, 5'd11, 32'h0, -1, 0);
            run_op("rnd_lw", ID_LW, ra, 32'h0, 5'd12, rw, -1, 0);
            run_op("rnd_lb", ID_LB, ra, 32'h0, 5'd13,
                   {{24{rw[7]}}, rw[7:0]}, -1, 0);
            run_op("rnd_lhu", ID_LHU, ra, 32'h0, 5'd14,
                   {16'h0, rw[15:0]}, -1, 0);
            run_op("rnd_sb", ID_SB, ra + 18'd1, {24'h0, ~rw[15:8]}, 5'd15,
                   32'h0, 1, 0);
            run_op("rnd_lh", ID_LH, ra, 32'h0, 5'd16,
                   {{16{~rw[15]}}, ~rw[15:8], rw[7:0]}, 0, 2);
        end

        instIdx_in = ID_NOP;
        rdE_in     = 1'b0;
        repeat (3) @(posedge clk_in);
        chk("res_left", res_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
